// File: rtl/lif_pkg.sv
// Shared types and helpers for the LIF neuron array.
package lif_pkg;

  typedef enum logic {
    RST_ZERO,
    RST_SUBTRACT
  } lif_reset_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    DONE
  } lif_state_e;

  // Unsigned add of two values of up to 32 bits, clamped to 2^width-1.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned width);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << width) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/lif_update_core.sv
// Combinational single-neuron LIF update: leak, integrate, fire, refractory.
module lif_update_core
  import lif_pkg::*;
#(
  parameter int unsigned     DATA_W       = 8,
  parameter int unsigned     FRAC_W       = 4,
  parameter int unsigned     THRESHOLD    = 64,
  parameter int unsigned     LEAK_FACTOR  = 12,
  parameter int unsigned     REFRAC_STEPS = 2,
  parameter int unsigned     REFRAC_W     = 2,
  parameter lif_reset_mode_e RESET_MODE   = RST_ZERO
) (
  input  logic [DATA_W-1:0]   pot,
  input  logic [REFRAC_W-1:0] refrac,
  input  logic [DATA_W-1:0]   current,
  output logic [DATA_W-1:0]   pot_next,
  output logic [REFRAC_W-1:0] refrac_next,
  output logic                spike
);

  localparam logic [DATA_W-1:0]   MaxVal     = '1;
  localparam logic [2*DATA_W-1:0] LeakF      = (2*DATA_W)'(LEAK_FACTOR);
  localparam logic [DATA_W-1:0]   ThrD       = DATA_W'(THRESHOLD);
  localparam logic [REFRAC_W-1:0] RefracInit = REFRAC_W'(REFRAC_STEPS);

  logic [2*DATA_W-1:0] prod;
  logic [2*DATA_W-1:0] leak_wide;
  logic [DATA_W-1:0]   leak;
  logic [DATA_W-1:0]   sum_sat;

  // Leak in double width, clamp, then saturating integrate and threshold test.
  always_comb begin
    prod        = {{DATA_W{1'b0}}, pot} * LeakF;
    leak_wide   = prod >> FRAC_W;
    leak        = (leak_wide > {{DATA_W{1'b0}}, MaxVal}) ? MaxVal : leak_wide[DATA_W-1:0];
    sum_sat     = DATA_W'(sat_add(32'(leak), 32'(current), DATA_W));
    pot_next    = sum_sat;
    refrac_next = refrac;
    spike       = 1'b0;
    if (refrac != '0) begin
      // Held neuron: input ignored, potential pinned at zero.
      refrac_next = refrac - REFRAC_W'(1);
      pot_next    = '0;
    end else if (32'(sum_sat) >= THRESHOLD) begin
      spike       = 1'b1;
      refrac_next = RefracInit;
      pot_next    = (RESET_MODE == RST_SUBTRACT) ? (sum_sat - ThrD) : '0;
    end
  end

endmodule

// File: rtl/lif_neuron_array.sv
// Array of LIF neurons updated one per cycle through a shared core.
module lif_neuron_array
  import lif_pkg::*;
#(
  parameter int unsigned     N_NEURONS    = 4,
  parameter int unsigned     DATA_W       = 8,
  parameter int unsigned     FRAC_W       = 4,
  parameter int unsigned     THRESHOLD    = 64,
  parameter int unsigned     LEAK_FACTOR  = 12,
  parameter int unsigned     REFRAC_STEPS = 2,
  parameter lif_reset_mode_e RESET_MODE   = RST_ZERO
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_NEURONS*DATA_W-1:0]   in_current,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_NEURONS-1:0]          out_spike,
  output logic [N_NEURONS*DATA_W-1:0]   out_potential
);

  localparam int unsigned IdxW    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam int unsigned RefracW = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_NEURONS - 1);

  lif_state_e state_q, state_d;

  logic [IdxW-1:0]             idx_q;
  logic [DATA_W-1:0]           cur_q    [N_NEURONS];
  logic [DATA_W-1:0]           pot_q    [N_NEURONS];
  logic [RefracW-1:0]          refrac_q [N_NEURONS];
  logic [N_NEURONS-1:0]        spike_acc_q;
  logic                        out_valid_q;
  logic [N_NEURONS-1:0]        out_spike_q;
  logic [N_NEURONS*DATA_W-1:0] out_pot_q;

  logic [DATA_W-1:0]  core_pot_next;
  logic [RefracW-1:0] core_refrac_next;
  logic               core_spike;

  lif_update_core #(
    .DATA_W      (DATA_W),
    .FRAC_W      (FRAC_W),
    .THRESHOLD   (THRESHOLD),
    .LEAK_FACTOR (LEAK_FACTOR),
    .REFRAC_STEPS(REFRAC_STEPS),
    .REFRAC_W    (RefracW),
    .RESET_MODE  (RESET_MODE)
  ) u_core (
    .pot        (pot_q[idx_q]),
    .refrac     (refrac_q[idx_q]),
    .current    (cur_q[idx_q]),
    .pot_next   (core_pot_next),
    .refrac_next(core_refrac_next),
    .spike      (core_spike)
  );

  // Next-state logic; DONE exits only once the registered output is visible.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = UPDATE;
      UPDATE:  if (idx_q == LastIdx) state_d = DONE;
      DONE:    if (out_valid_q && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath: latch currents, sweep neurons, then load the output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      spike_acc_q <= '0;
      out_valid_q <= 1'b0;
      out_spike_q <= '0;
      out_pot_q   <= '0;
      for (int unsigned i = 0; i < N_NEURONS; i++) begin
        cur_q[i]    <= '0;
        pot_q[i]    <= '0;
        refrac_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            idx_q <= '0;
            for (int unsigned i = 0; i < N_NEURONS; i++) begin
              cur_q[i] <= in_current[i*DATA_W +: DATA_W];
            end
          end
        end
        UPDATE: begin
          pot_q[idx_q]       <= core_pot_next;
          refrac_q[idx_q]    <= core_refrac_next;
          spike_acc_q[idx_q] <= core_spike;
          idx_q              <= (idx_q == LastIdx) ? '0 : idx_q + IdxW'(1);
        end
        DONE: begin
          // First DONE cycle snapshots the finished timestep into the outputs.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_spike_q <= spike_acc_q;
            for (int unsigned i = 0; i < N_NEURONS; i++) begin
              out_pot_q[i*DATA_W +: DATA_W] <= pot_q[i];
            end
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign out_valid     = out_valid_q;
  assign out_spike     = out_spike_q;
  assign out_potential = out_pot_q;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed self-checking bench for lif_neuron_array (default, subtract and saturation builds).
module tb_lif_neuron_array;
  import lif_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_current;

  logic        ir_a, ov_a, ir_b, ov_b, ir_c, ov_c;
  logic [3:0]  spk_a, spk_b, spk_c;
  logic [31:0] pot_a, pot_b, pot_c;

  int checks = 0;
  int errors = 0;

  logic [3:0]  cap_spk [3];
  logic [31:0] cap_pot [3];
  int          cap_lat;

  always #5 clk = ~clk;

  lif_neuron_array dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_a), .in_current(in_current),
    .out_valid(ov_a), .out_ready(out_ready), .out_spike(spk_a), .out_potential(pot_a)
  );

  lif_neuron_array #(.RESET_MODE(RST_SUBTRACT)) dut_sub (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_b), .in_current(in_current),
    .out_valid(ov_b), .out_ready(out_ready), .out_spike(spk_b), .out_potential(pot_b)
  );

  lif_neuron_array #(.THRESHOLD(255)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_c), .in_current(in_current),
    .out_valid(ov_c), .out_ready(out_ready), .out_spike(spk_c), .out_potential(pot_c)
  );

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_current = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One full timestep: accept, wait (bounded) for out_valid, capture, handshake.
  task automatic run_step(input logic [31:0] cur);
    in_current = cur; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cap_lat = 0;
    while (!ov_a && cap_lat < 50) begin
      @(posedge clk); #1;
      cap_lat++;
    end
    cap_spk[0] = spk_a; cap_pot[0] = pot_a;
    cap_spk[1] = spk_b; cap_pot[1] = pot_b;
    cap_spk[2] = spk_c; cap_pot[2] = pot_c;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ir_a !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", ir_a); end
    checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", ov_a); end
    checks++; if (spk_a !== 4'h0) begin errors++; $display("FAIL reset_spike: got %h expected 0", spk_a); end
    checks++; if (pot_a !== 32'h0) begin errors++; $display("FAIL reset_potential: got %h expected 0", pot_a); end
  endtask

  // Neuron0 driven with 32 each step: integrate, fire, refractory, recover.
  task automatic test_integrate_refrac();
    logic [31:0] exp_pot [6];
    logic [3:0]  exp_spk [6];
    exp_pot = '{32'h20, 32'h38, 32'h0, 32'h0, 32'h0, 32'h20};
    exp_spk = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0};
    do_reset();
    for (int s = 0; s < 6; s++) begin
      run_step(32'h0000_0020);
      checks++;
      if (cap_pot[0] !== exp_pot[s]) begin
        errors++; $display("FAIL integrate_pot step%0d: got %h expected %h", s + 1, cap_pot[0], exp_pot[s]);
      end
      checks++;
      if (cap_spk[0] !== exp_spk[s]) begin
        errors++; $display("FAIL integrate_spike step%0d: got %h expected %h", s + 1, cap_spk[0], exp_spk[s]);
      end
      if (s == 0) begin
        checks++;
        if (cap_lat !== 5) begin errors++; $display("FAIL integrate_latency: got %0d expected 5", cap_lat); end
      end
    end
  endtask

  task automatic test_subtract();
    logic [31:0] exp_pot [3];
    exp_pot = '{32'h20, 32'h38, 32'h0A};
    do_reset();
    for (int s = 0; s < 3; s++) begin
      run_step(32'h0000_0020);
      checks++;
      if (cap_pot[1] !== exp_pot[s]) begin
        errors++; $display("FAIL subtract_pot step%0d: got %h expected %h", s + 1, cap_pot[1], exp_pot[s]);
      end
    end
    checks++;
    if (cap_spk[1] !== 4'h1) begin errors++; $display("FAIL subtract_spike: got %h expected 1", cap_spk[1]); end
  endtask

  // Distinct currents per neuron: below, at and above threshold, plus independence.
  task automatic test_independent();
    do_reset();
    run_step(32'h4064_103F);
    checks++; if (cap_spk[0] !== 4'hC) begin errors++; $display("FAIL indep_spike1: got %h expected c", cap_spk[0]); end
    checks++; if (cap_pot[0] !== 32'h0000_103F) begin errors++; $display("FAIL indep_pot1: got %h expected 0000103f", cap_pot[0]); end
    checks++; if (cap_pot[1] !== 32'h0024_103F) begin errors++; $display("FAIL indep_sub_pot1: got %h expected 0024103f", cap_pot[1]); end
    run_step(32'h4064_103F);
    checks++; if (cap_spk[0] !== 4'h1) begin errors++; $display("FAIL indep_spike2: got %h expected 1", cap_spk[0]); end
    checks++; if (cap_pot[0] !== 32'h0000_1C00) begin errors++; $display("FAIL indep_pot2: got %h expected 00001c00", cap_pot[0]); end
    checks++; if (cap_pot[1] !== 32'h0000_1C2E) begin errors++; $display("FAIL indep_sub_pot2: got %h expected 00001c2e", cap_pot[1]); end
  endtask

  task automatic test_saturate();
    do_reset();
    run_step(32'h0000_00C8);
    checks++; if (cap_pot[2] !== 32'h0000_00C8) begin errors++; $display("FAIL sat_pot1: got %h expected 000000c8", cap_pot[2]); end
    checks++; if (cap_spk[2] !== 4'h0) begin errors++; $display("FAIL sat_spike1: got %h expected 0", cap_spk[2]); end
    run_step(32'h0000_00C8);
    checks++; if (cap_spk[2] !== 4'h1) begin errors++; $display("FAIL sat_spike2: got %h expected 1", cap_spk[2]); end
    checks++; if (cap_pot[2] !== 32'h0) begin errors++; $display("FAIL sat_pot2: got %h expected 0", cap_pot[2]); end
  endtask

  task automatic test_backpressure();
    int lat;
    do_reset();
    in_current = 32'h0000_0020; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!ov_a && lat < 50) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 5) begin errors++; $display("FAIL bp_latency: got %0d expected 5", lat); end
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin in_current = 32'h0000_0040; in_valid = 1'b1; end
      checks++; if (ov_a !== 1'b1) begin errors++; $display("FAIL bp_valid c%0d: got %b expected 1", c, ov_a); end
      checks++; if (ir_a !== 1'b0) begin errors++; $display("FAIL bp_in_ready c%0d: got %b expected 0", c, ir_a); end
      checks++; if (pot_a !== 32'h20) begin errors++; $display("FAIL bp_pot c%0d: got %h expected 00000020", c, pot_a); end
      checks++; if (spk_a !== 4'h0) begin errors++; $display("FAIL bp_spike c%0d: got %h expected 0", c, spk_a); end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL bp_valid_drop: got %b expected 0", ov_a); end
    checks++; if (ir_a !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b expected 1", ir_a); end
    run_step(32'h0000_0020);
    checks++; if (cap_pot[0] !== 32'h38) begin errors++; $display("FAIL bp_next_pot: got %h expected 00000038", cap_pot[0]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_step(32'h0000_0020);
    run_step(32'h0000_0020);
    in_current = 32'h0000_0020; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", ov_a); end
    checks++; if (ir_a !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b expected 1", ir_a); end
    checks++; if (pot_a !== 32'h0) begin errors++; $display("FAIL mid_potential: got %h expected 0", pot_a); end
    checks++; if (spk_a !== 4'h0) begin errors++; $display("FAIL mid_spike: got %h expected 0", spk_a); end
    run_step(32'h0000_0020);
    checks++; if (cap_lat !== 5) begin errors++; $display("FAIL mid_latency: got %0d expected 5", cap_lat); end
    checks++; if (cap_pot[0] !== 32'h20) begin errors++; $display("FAIL mid_fresh_pot: got %h expected 00000020", cap_pot[0]); end
    checks++; if (cap_spk[0] !== 4'h0) begin errors++; $display("FAIL mid_fresh_spike: got %h expected 0", cap_spk[0]); end
  endtask

  initial begin
    test_reset();
    test_integrate_refrac();
    test_subtract();
    test_independent();
    test_saturate();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
